// File: rtl/md_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
package md_pkg;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the mult/div unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  // Requester side (control unit).
  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  // Execution side (the unit itself).
  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/md_step.sv
// One iteration of the shared datapath: radix-2 Booth step or restoring-divide step.
// Accumulator layout: {A/R [WIDTH:0], Q [WIDTH-1:0], q_-1}.
module md_step
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_ITER
) (
  input  logic              op,
  input  logic [2*WIDTH+1:0] acc,
  input  logic [WIDTH-1:0]  m,
  output logic [2*WIDTH+1:0] acc_nxt,
  output logic              q_bit
);

  localparam int unsigned AW = 2 * WIDTH + 2;

  logic [WIDTH:0]   a_part;
  logic [WIDTH-1:0] q_part;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_new;
  logic [WIDTH+1:0] trial;

  // Both candidate next states; op selects which one leaves the block.
  always_comb begin
    a_part = acc[AW-1:WIDTH+1];
    q_part = acc[WIDTH:1];

    // MULT: m is the signed multiplicand, sign-extended into the guard bit.
    m_ext = {m[WIDTH-1], m};
    case (acc[1:0])
      2'b01:   booth_sum = a_part + m_ext;
      2'b10:   booth_sum = a_part - m_ext;
      default: booth_sum = a_part;
    endcase

    // DIV: m is the divisor magnitude; one extra bit keeps the trial sign.
    r_sh  = {a_part[WIDTH-1:0], q_part[WIDTH-1]};
    trial = {1'b0, r_sh} - {2'b00, m};
    r_new = trial[WIDTH+1] ? r_sh : trial[WIDTH:0];

    if (op == MD_DIV) begin
      // Quotient bit slot (acc[1]) is left zero; the caller merges q_bit in.
      acc_nxt = {r_new, q_part[WIDTH-2:0], 2'b00};
      q_bit   = ~trial[WIDTH+1];
    end else begin
      acc_nxt = {booth_sum[WIDTH], booth_sum, q_part};
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: WIDTH iterations, registered HI/LO results.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_ITER
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned AW = 2 * WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    step_acc;
  logic [AW-1:0]    step_merged;
  logic             step_qbit;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             op_q, qneg_q, rneg_q, dz_q;

  logic             accept;
  logic             dz_req;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] r_mag, q_mag;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign accept = (state_q == IDLE) && bus.start;
  assign dz_req = (bus.op == MD_DIV) && (bus.b == '0);
  // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
  assign a_mag  = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign b_mag  = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

  md_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .m       (m_q),
    .acc_nxt (step_acc),
    .q_bit   (step_qbit)
  );

  // Drop the new quotient bit into Q[0] for DIV; Booth output is already complete.
  assign step_merged = (op_q == MD_DIV) ? {step_acc[AW-1:2], step_qbit, step_acc[0]} : step_acc;

  // Final sign fix-up: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    r_mag  = acc_q[2*WIDTH:WIDTH+1];
    q_mag  = acc_q[WIDTH:1];
    res_hi = r_mag;
    res_lo = q_mag;
    if (op_q == MD_DIV) begin
      res_hi = rneg_q ? (~r_mag + 1'b1) : r_mag;
      res_lo = qneg_q ? (~q_mag + 1'b1) : q_mag;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = dz_req ? DONE : RUN;
      RUN:     if (cnt_q == LastCnt) state_d = FINISH;
      FINISH:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    bus.busy     = (state_q == RUN) || (state_q == FINISH);
    bus.done     = (state_q == DONE);
    bus.div_zero = (state_q == DONE) && dz_q;
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      m_q    <= '0;
      op_q   <= MD_MULT;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.op;
            dz_q   <= dz_req;
            cnt_q  <= '0;
            qneg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            rneg_q <= bus.a[WIDTH-1];
            if (bus.op == MD_DIV) begin
              acc_q <= {{(WIDTH + 1){1'b0}}, a_mag, 1'b0};
              m_q   <= b_mag;
            end else begin
              acc_q <= {{(WIDTH + 1){1'b0}}, bus.a, 1'b0};
              m_q   <= bus.b;
            end
          end
        end
        RUN: begin
          acc_q <= step_merged;
          cnt_q <= cnt_q + 1'b1;
        end
        FINISH: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule
